// File: rtl/sync_fifo_ctrl_mem_if.sv
// Write/read handshake and status bundle for the single-clock FIFO.
// The master side drives requests; the slave side (the FIFO) returns data and status.
interface sync_fifo_ctrl_mem_if #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
);
    logic                winc;
    logic [DATASIZE-1:0] wdata;
    logic                wfull;
    logic                walmost_full;
    logic                rinc;
    logic [DATASIZE-1:0] rdata;
    logic                rvalid;
    logic                rempty;
    logic                ralmost_empty;
    logic [ADDRSIZE:0]   count;
    logic                overflow;
    logic                underflow;

    modport master (
        output winc, wdata, rinc,
        input  wfull, walmost_full, rdata, rvalid, rempty, ralmost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  winc, wdata, rinc,
        output wfull, walmost_full, rdata, rvalid, rempty, ralmost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ctrl_mem.sv
// Single-clock FIFO: storage array, binary pointers, occupancy count,
// registered status flags, registered read port and sticky error flags.
module sync_fifo_ctrl_mem #(
    parameter int DATASIZE     = 8,
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_LEVEL  = 14,
    parameter int AEMPTY_LEVEL = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    sync_fifo_ctrl_mem_if.slave   fifo
);
    localparam int DEPTH = 2 ** ADDRSIZE;
    localparam logic [ADDRSIZE:0] DEPTH_C  = (ADDRSIZE+1)'(DEPTH);
    localparam logic [ADDRSIZE:0] AFULL_C  = (ADDRSIZE+1)'(AFULL_LEVEL);
    localparam logic [ADDRSIZE:0] AEMPTY_C = (ADDRSIZE+1)'(AEMPTY_LEVEL);

    logic [DATASIZE-1:0] mem [DEPTH];

    logic [ADDRSIZE-1:0] wptr_q, rptr_q;
    logic [ADDRSIZE:0]   count_q, count_d;
    logic [DATASIZE-1:0] rdata_q;
    logic                rvalid_q;
    logic                wfull_q, rempty_q, afull_q, aempty_q;
    logic                ovf_q, udf_q;
    logic                wr_ok, rd_ok;

    // Acceptance looks only at registered flags, never at the opposite request.
    assign wr_ok = fifo.winc & ~wfull_q;
    assign rd_ok = fifo.rinc & ~rempty_q;

    always_comb begin
        count_d = count_q;
        if (wr_ok && !rd_ok) begin
            count_d = count_q + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ok && !rst) begin
            mem[wptr_q] <= fifo.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            wfull_q  <= 1'b0;
            rempty_q <= 1'b1;
            afull_q  <= (AFULL_LEVEL == 0);
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr_q <= wptr_q + 1'b1;
            end
            rvalid_q <= rd_ok;
            if (rd_ok) begin
                rdata_q <= mem[rptr_q];
                rptr_q  <= rptr_q + 1'b1;
            end
            count_q  <= count_d;
            // Flags come from the next count so they move on the same edge as count.
            wfull_q  <= (count_d == DEPTH_C);
            rempty_q <= (count_d == '0);
            afull_q  <= (count_d >= AFULL_C);
            aempty_q <= (count_d <= AEMPTY_C);
            if (fifo.winc && wfull_q) begin
                ovf_q <= 1'b1;
            end
            if (fifo.rinc && rempty_q) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign fifo.rdata         = rdata_q;
    assign fifo.rvalid        = rvalid_q;
    assign fifo.count         = count_q;
    assign fifo.wfull         = wfull_q;
    assign fifo.rempty        = rempty_q;
    assign fifo.walmost_full  = afull_q;
    assign fifo.ralmost_empty = aempty_q;
    assign fifo.overflow      = ovf_q;
    assign fifo.underflow     = udf_q;
endmodule

// File: tb/tb_sync_fifo_ctrl_mem.sv
// Directed bench for sync_fifo_ctrl_mem: fill/drain, boundary collisions,
// pointer wrap with concurrent traffic, and reset during traffic.
module tb_sync_fifo_ctrl_mem;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    sync_fifo_ctrl_mem_if #(.DATASIZE(8), .ADDRSIZE(4)) bus ();

    sync_fifo_ctrl_mem #(
        .DATASIZE(8), .ADDRSIZE(4), .AFULL_LEVEL(14), .AEMPTY_LEVEL(2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .fifo (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply inputs, take one rising edge, settle outputs 1 time unit later.
    task automatic step(input logic r, input logic w, input logic [7:0] d, input logic rd);
        rst       = r;
        bus.winc  = w;
        bus.wdata = d;
        bus.rinc  = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"},  32'(bus.count), 0);
        chk({tag, "_rempty"}, 32'(bus.rempty), 1);
        chk({tag, "_raempty"},32'(bus.ralmost_empty), 1);
        chk({tag, "_wfull"},  32'(bus.wfull), 0);
        chk({tag, "_wafull"}, 32'(bus.walmost_full), 0);
        chk({tag, "_rvalid"}, 32'(bus.rvalid), 0);
        chk({tag, "_rdata"},  32'(bus.rdata), 0);
        chk({tag, "_ovf"},    32'(bus.overflow), 0);
        chk({tag, "_udf"},    32'(bus.underflow), 0);
    endtask

    initial begin
        bus.winc = 1'b0; bus.wdata = '0; bus.rinc = 1'b0;

        // 1: reset then fill with 0x01..0x10
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        chk_reset_state("rst");
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 8'(i + 1), 0);
            chk("fill_count",  32'(bus.count), i + 1);
            chk("fill_wafull", 32'(bus.walmost_full), 32'(i + 1 >= 14));
            chk("fill_wfull",  32'(bus.wfull), 32'(i + 1 == 16));
            chk("fill_rempty", 32'(bus.rempty), 0);
        end
        chk("fill_ovf", 32'(bus.overflow), 0);

        // 2: drain 16 words in order
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 8'h00, 1);
            chk("drain_rdata",   32'(bus.rdata), i + 1);
            chk("drain_rvalid",  32'(bus.rvalid), 1);
            chk("drain_count",   32'(bus.count), 15 - i);
            chk("drain_raempty", 32'(bus.ralmost_empty), 32'(15 - i <= 2));
            chk("drain_rempty",  32'(bus.rempty), 32'(i == 15));
        end
        step(0, 0, 8'h00, 0);
        chk("drain_idle_rvalid", 32'(bus.rvalid), 0);
        chk("drain_idle_rdata",  32'(bus.rdata), 32'h10);
        chk("drain_udf",         32'(bus.underflow), 0);

        // 3: full + simultaneous write/read: read wins, write dropped
        for (int i = 0; i < 16; i++) step(0, 1, 8'(i + 1), 0);
        chk("full_wfull", 32'(bus.wfull), 1);
        step(0, 1, 8'hAA, 1);
        chk("fullrw_rdata",  32'(bus.rdata), 32'h01);
        chk("fullrw_rvalid", 32'(bus.rvalid), 1);
        chk("fullrw_count",  32'(bus.count), 15);
        chk("fullrw_ovf",    32'(bus.overflow), 1);
        chk("fullrw_wfull",  32'(bus.wfull), 0);
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 8'h00, 1);
            chk("fullrw_drain", 32'(bus.rdata), i + 2);
        end
        chk("fullrw_empty",      32'(bus.rempty), 1);
        chk("fullrw_ovf_sticky", 32'(bus.overflow), 1);

        // 4: empty + simultaneous write/read: write wins, read dropped
        step(0, 1, 8'h5C, 1);
        chk("emptyrw_rvalid", 32'(bus.rvalid), 0);
        chk("emptyrw_count",  32'(bus.count), 1);
        chk("emptyrw_udf",    32'(bus.underflow), 1);
        chk("emptyrw_rempty", 32'(bus.rempty), 0);
        step(0, 0, 8'h00, 1);
        chk("emptyrw_rdata",  32'(bus.rdata), 32'h5C);
        chk("emptyrw_rv2",    32'(bus.rvalid), 1);
        chk("emptyrw_count2", 32'(bus.count), 0);
        step(0, 0, 8'h00, 0);
        chk("udf_sticky", 32'(bus.underflow), 1);

        // 5: wrap with concurrent traffic
        step(1, 0, 8'h00, 0);
        chk_reset_state("rst2");
        for (int i = 0; i < 10; i++) step(0, 1, 8'(8'h20 + i), 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 8'h00, 1);
            chk("pre_wrap_rdata", 32'(bus.rdata), 32'h20 + i);
        end
        for (int i = 0; i < 3; i++) step(0, 1, 8'(8'h40 + i), 0);
        chk("wrap_count_pre", 32'(bus.count), 3);
        for (int j = 0; j < 9; j++) begin
            step(0, 1, 8'(8'h43 + j), 1);
            chk("wrap_rdata",  32'(bus.rdata), 32'h40 + j);
            chk("wrap_rvalid", 32'(bus.rvalid), 1);
            chk("wrap_count",  32'(bus.count), 3);
        end
        for (int j = 0; j < 3; j++) begin
            step(0, 0, 8'h00, 1);
            chk("wrap_tail", 32'(bus.rdata), 32'h49 + j);
        end
        chk("wrap_empty", 32'(bus.rempty), 1);

        // 6: reset at count=7 with requests asserted
        for (int i = 0; i < 7; i++) step(0, 1, 8'(8'h60 + i), 0);
        chk("pre_rst_count", 32'(bus.count), 7);
        step(1, 1, 8'hEE, 1);
        chk_reset_state("rst3");
        step(0, 1, 8'h99, 0);
        chk("post_rst_count", 32'(bus.count), 1);
        step(0, 0, 8'h00, 1);
        chk("post_rst_rdata",  32'(bus.rdata), 32'h99);
        chk("post_rst_rvalid", 32'(bus.rvalid), 1);
        chk("post_rst_empty",  32'(bus.rempty), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
